// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader: FSM state encoding, operand width, key indices.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package operand_loader_pkg;

    localparam int OPERAND_W = 4;

    // Pushbutton positions on KEY[3:0]
    localparam int KEY_RST  = 0;
    localparam int KEY_LOAD = 1;
    localparam int KEY_ACK  = 2;
    localparam int KEY_CLR  = 3;

    // 2'd3 is not a working state; the FSM steers it back to LOAD_A.
    typedef enum logic [1:0] {
        LOAD_A     = 2'd0,
        LOAD_B     = 2'd1,
        HOLD       = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_e;

endpackage

// File: rtl/operand_loader_key_debounce.sv
// Pushbutton conditioner: synchroniser, stable-level debounce counter, one-cycle press pulse.
// Latency: press pulse SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles after a clean key-down.
// Backpressure: none; a pulse is a one-shot event and is not held.
// Ports: CLOCK_50 clock, rst_n sync active-low reset, key_in raw active-low key,
//        press one-cycle high pulse on each accepted 1->0 transition.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic CLOCK_50,
    input  logic rst_n,
    input  logic key_in,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // The toggle happens on the cycle that would take the count to DEBOUNCE_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   db_prev_q;
    logic                   press_q, press_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d   = '0;
        db_d    = db_q;
        // Any cycle of agreement restarts the count from zero.
        if (synced != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Falling edge of the debounced level, seen one register later.
        press_d = db_prev_q & ~db_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            sync_q    <= '1;
            cnt_q     <= '0;
            db_q      <= 1'b1;
            db_prev_q <= 1'b1;
            press_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], key_in};
            cnt_q     <= cnt_d;
            db_q      <= db_d;
            db_prev_q <= db_q;
            press_q   <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/operand_loader.sv
// Sequential operand capture for the 4-bit adder: A, then B + carry-in, held with a valid flag.
// Latency: operands update on the edge after a debounced press pulse; LEDR updates on the same edge.
// Backpressure: held set is frozen until ack or clear; extra load presses in HOLD are dropped.
// Ports: CLOCK_50 clock; KEY[0] sync reset, KEY[1] load, KEY[2] ack, KEY[3] clear (all active-low);
//        SW[3:0] data, SW[9] carry-in; op_a/op_b/op_cin/op_valid to adder; LEDR status.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                 CLOCK_50,
    input  logic [3:0]           KEY,
    input  logic [9:0]           SW,
    output logic [OPERAND_W-1:0] op_a,
    output logic [OPERAND_W-1:0] op_b,
    output logic                 op_cin,
    output logic                 op_valid,
    output logic [9:0]           LEDR
);

    logic rst_n;
    logic load_pulse, ack_pulse, clr_pulse;

    // Reset goes straight to the flops: no synchroniser, no debounce.
    assign rst_n = KEY[KEY_RST];

    // SW[8:4] have no function on this board layout.
    logic unused_sw;
    assign unused_sw = ^SW[8:4];

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_load_db (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .key_in   (KEY[KEY_LOAD]),
        .press    (load_pulse)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_ack_db (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .key_in   (KEY[KEY_ACK]),
        .press    (ack_pulse)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_clr_db (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .key_in   (KEY[KEY_CLR]),
        .press    (clr_pulse)
    );

    state_e               state_q, state_d;
    logic [OPERAND_W-1:0] op_a_q, op_a_d;
    logic [OPERAND_W-1:0] op_b_q, op_b_d;
    logic                 op_cin_q, op_cin_d;
    logic                 op_valid_q, op_valid_d;
    logic [9:0]           ledr_q, ledr_d;

    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_cin_d   = op_cin_q;
        op_valid_d = op_valid_q;

        // Clear outranks everything; ack/load are simply not looked at that cycle.
        if (clr_pulse) begin
            state_d    = LOAD_A;
            op_a_d     = '0;
            op_b_d     = '0;
            op_cin_d   = 1'b0;
            op_valid_d = 1'b0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (load_pulse) begin
                        op_a_d  = SW[OPERAND_W-1:0];
                        state_d = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (load_pulse) begin
                        op_b_d     = SW[OPERAND_W-1:0];
                        op_cin_d   = SW[9];
                        op_valid_d = 1'b1;
                        state_d    = HOLD;
                    end
                end
                HOLD: begin
                    // Load is ignored here so the consumer sees stable operands.
                    if (ack_pulse) begin
                        op_valid_d = 1'b0;
                        state_d    = LOAD_A;
                    end
                end
                default: begin
                    state_d    = LOAD_A;
                    op_valid_d = 1'b0;
                end
            endcase
        end

        // Status reflects the post-update values so LEDR tracks the state register exactly.
        ledr_d = {op_valid_d, (state_d == LOAD_B), op_b_d, op_a_d};
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state_q    <= LOAD_A;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_cin_q   <= 1'b0;
            op_valid_q <= 1'b0;
            ledr_q     <= '0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_cin_q   <= op_cin_d;
            op_valid_q <= op_valid_d;
            ledr_q     <= ledr_d;
        end
    end

    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_cin   = op_cin_q;
    assign op_valid = op_valid_q;
    assign LEDR     = ledr_q;

endmodule
